// File: rtl/video_timing_sched_if.sv
// Register/commit port of the video timing scheduler.
// Handshake: cfg_wr, cfg_rd and cfg_commit are single-cycle strobes qualified
// only by the clock edge (no ready/backpressure); cfg_addr/cfg_wdata are valid
// in any cycle with a strobe; cfg_rdata is registered and updates one cycle
// after cfg_rd, holding its value otherwise.
interface video_timing_sched_if;
    logic        cfg_wr;
    logic        cfg_rd;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic        cfg_commit;

    modport master (
        output cfg_wr, cfg_rd, cfg_addr, cfg_wdata, cfg_commit,
        input  cfg_rdata
    );
    modport slave (
        input  cfg_wr, cfg_rd, cfg_addr, cfg_wdata, cfg_commit,
        output cfg_rdata
    );
endinterface

// File: rtl/video_timing_sched.sv
// Timing/polarity staging, atomic apply and frame-aligned enable sequencing
// for the video pixel generator.
// Optional macro VID_UNDERRUN_CNT_EN: enables the saturating underrun counter
// at register address 0xA (otherwise that address reads 0, writes ignored).
module video_timing_sched #(
    parameter logic [19:0] STOP_TMO = 20'hFFFFF,
    parameter int          UCNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    video_timing_sched_if.slave  cfg,
    input  logic                 eov,
    input  logic                 load_ready,
    input  logic                 load_valid,
    output logic                 ctrl_ven,
    output logic                 ctrl_hsync_pol,
    output logic                 ctrl_vsync_pol,
    output logic                 ctrl_blank_pol,
    output logic                 ctrl_daten_pol,
    output logic [7:0]           Thsync,
    output logic [7:0]           Thgdel,
    output logic [7:0]           Tvsync,
    output logic [7:0]           Tvgdel,
    output logic [15:0]          Thgate,
    output logic [15:0]          Thlen,
    output logic [15:0]          Tvgate,
    output logic [15:0]          Tvlen,
    output logic                 commit_pend,
    output logic                 frame_irq
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP_PEND = 2'd2} state_t;

    localparam logic [19:0] TMO_LAST = STOP_TMO - 20'd1;

    state_t      state, state_nxt;
    logic [4:0]  stg_ctrl;
    logic [7:0]  stg_thsync, stg_thgdel, stg_tvsync, stg_tvgdel;
    logic [15:0] stg_thgate, stg_thlen, stg_tvgate, stg_tvlen;
    logic        eov_q, eov_edge;
    logic        pend, pend_nxt;
    logic [19:0] tmo_cnt;
    logic        tmo_hit, tmo_clr;
    logic        ld_all, ld_ven, ven_clr;
    logic        running;
    logic [15:0] rd_mux, ucnt_rd;

    assign eov_edge    = eov & ~eov_q;
    assign tmo_hit     = (tmo_cnt == TMO_LAST);
    assign running     = (state == RUN) || (state == STOP_PEND);
    // A commit latched during STOP_PEND is consumed in the first IDLE cycle and is not reported there.
    assign commit_pend = pend && (state != IDLE);

    // State, pending flag, eov history and boundary interrupt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend      <= 1'b0;
            eov_q     <= 1'b0;
            frame_irq <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend      <= pend_nxt;
            eov_q     <= eov;
            frame_irq <= eov_edge && (state == RUN);
        end
    end

    // Next state and apply/stop decisions.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        ld_all    = 1'b0;
        ld_ven    = 1'b0;
        ven_clr   = 1'b0;
        tmo_clr   = 1'b0;
        case (state)
            IDLE: begin
                pend_nxt = 1'b0;
                if (cfg.cfg_commit || pend) begin
                    ld_all = 1'b1;
                    ld_ven = 1'b1;
                    if (stg_ctrl[0]) state_nxt = RUN;
                end
            end
            RUN: begin
                // A commit arriving with the boundary only becomes pending; it waits a full frame.
                if (eov_edge && pend) begin
                    ld_all   = 1'b1;
                    pend_nxt = 1'b0;
                    if (!stg_ctrl[0]) begin
                        state_nxt = STOP_PEND;
                        tmo_clr   = 1'b1;
                    end
                end else if (cfg.cfg_commit) begin
                    pend_nxt = 1'b1;
                end
            end
            STOP_PEND: begin
                if (cfg.cfg_commit) pend_nxt = 1'b1;
                if (eov_edge || tmo_hit) begin
                    ven_clr   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stop timeout counter, cleared on entry to STOP_PEND.
    always_ff @(posedge clk) begin
        if (!rst_n || tmo_clr) tmo_cnt <= '0;
        else if (state == STOP_PEND) tmo_cnt <= tmo_cnt + 20'd1;
    end

    // Staging registers; a write in an apply cycle lands after the apply samples them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_ctrl   <= '0;
            stg_thsync <= '0;
            stg_thgdel <= '0;
            stg_thgate <= '0;
            stg_thlen  <= '0;
            stg_tvsync <= '0;
            stg_tvgdel <= '0;
            stg_tvgate <= '0;
            stg_tvlen  <= '0;
        end else if (cfg.cfg_wr) begin
            case (cfg.cfg_addr)
                4'h0: stg_ctrl   <= cfg.cfg_wdata[4:0];
                4'h1: stg_thsync <= cfg.cfg_wdata[7:0];
                4'h2: stg_thgdel <= cfg.cfg_wdata[7:0];
                4'h3: stg_thgate <= cfg.cfg_wdata;
                4'h4: stg_thlen  <= cfg.cfg_wdata;
                4'h5: stg_tvsync <= cfg.cfg_wdata[7:0];
                4'h6: stg_tvgdel <= cfg.cfg_wdata[7:0];
                4'h7: stg_tvgate <= cfg.cfg_wdata;
                4'h8: stg_tvlen  <= cfg.cfg_wdata;
                default: ;
            endcase
        end
    end

    // Active copy driving the generator; ven is sequenced separately from the rest.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_ven       <= 1'b0;
            ctrl_hsync_pol <= 1'b0;
            ctrl_vsync_pol <= 1'b0;
            ctrl_blank_pol <= 1'b0;
            ctrl_daten_pol <= 1'b0;
            Thsync <= '0; Thgdel <= '0; Thgate <= '0; Thlen <= '0;
            Tvsync <= '0; Tvgdel <= '0; Tvgate <= '0; Tvlen <= '0;
        end else begin
            if (ld_all) begin
                ctrl_hsync_pol <= stg_ctrl[1];
                ctrl_vsync_pol <= stg_ctrl[2];
                ctrl_blank_pol <= stg_ctrl[3];
                ctrl_daten_pol <= stg_ctrl[4];
                Thsync <= stg_thsync; Thgdel <= stg_thgdel;
                Thgate <= stg_thgate; Thlen  <= stg_thlen;
                Tvsync <= stg_tvsync; Tvgdel <= stg_tvgdel;
                Tvgate <= stg_tvgate; Tvlen  <= stg_tvlen;
            end
            if (ld_ven) ctrl_ven <= stg_ctrl[0];
            else if (ven_clr) ctrl_ven <= 1'b0;
        end
    end

`ifdef VID_UNDERRUN_CNT_EN
    logic [UCNT_W-1:0] ucnt;

    // Saturating underrun counter; a clear write overrides a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n) ucnt <= '0;
        else if (cfg.cfg_wr && cfg.cfg_addr == 4'hA) ucnt <= '0;
        else if (running && load_ready && !load_valid && !(&ucnt)) ucnt <= ucnt + 1'b1;
    end

    assign ucnt_rd = 16'(ucnt);
`else
    localparam int unused_ucnt_w = UCNT_W;
    logic unused_underrun;
    assign unused_underrun = &{1'b0, load_ready, load_valid, running};
    assign ucnt_rd = '0;
`endif

    // Read mux over staging, status and underrun count.
    always_comb begin
        rd_mux = '0;
        case (cfg.cfg_addr)
            4'h0: rd_mux = {11'd0, stg_ctrl};
            4'h1: rd_mux = {8'd0, stg_thsync};
            4'h2: rd_mux = {8'd0, stg_thgdel};
            4'h3: rd_mux = stg_thgate;
            4'h4: rd_mux = stg_thlen;
            4'h5: rd_mux = {8'd0, stg_tvsync};
            4'h6: rd_mux = {8'd0, stg_tvgdel};
            4'h7: rd_mux = stg_tvgate;
            4'h8: rd_mux = stg_tvlen;
            4'h9: rd_mux = {13'd0, commit_pend, state};
            4'hA: rd_mux = ucnt_rd;
            default: rd_mux = '0;
        endcase
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) cfg.cfg_rdata <= '0;
        else if (cfg.cfg_rd) cfg.cfg_rdata <= rd_mux;
    end
endmodule

// File: tb/tb_video_timing_sched.sv
// Randomized + directed bench for video_timing_sched against a register-level
// reference model (staging/active arrays, mode integer, plain counters).
module tb_video_timing_sched;
    localparam logic [19:0] STOP_TMO = 20'd16;
    localparam int UCNT_MAX = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic eov, load_ready, load_valid;
    logic ctrl_ven, ctrl_hsync_pol, ctrl_vsync_pol, ctrl_blank_pol, ctrl_daten_pol;
    logic [7:0] Thsync, Thgdel, Tvsync, Tvgdel;
    logic [15:0] Thgate, Thlen, Tvgate, Tvlen;
    logic commit_pend, frame_irq;

    video_timing_sched_if cfg ();

    video_timing_sched #(.STOP_TMO(STOP_TMO), .UCNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg(cfg.slave), .eov(eov),
        .load_ready(load_ready), .load_valid(load_valid),
        .ctrl_ven(ctrl_ven), .ctrl_hsync_pol(ctrl_hsync_pol),
        .ctrl_vsync_pol(ctrl_vsync_pol), .ctrl_blank_pol(ctrl_blank_pol),
        .ctrl_daten_pol(ctrl_daten_pol),
        .Thsync(Thsync), .Thgdel(Thgdel), .Tvsync(Tvsync), .Tvgdel(Tvgdel),
        .Thgate(Thgate), .Thlen(Thlen), .Tvgate(Tvgate), .Tvlen(Tvlen),
        .commit_pend(commit_pend), .frame_irq(frame_irq)
    );

    always #5 clk = ~clk;

    // Stimulus holding variables (strobes auto-clear after each cycle).
    logic        d_wr, d_rd, d_commit, d_eov, d_lr, d_lv, d_rst_n;
    logic [3:0]  d_addr;
    logic [15:0] d_wdata;

    // Reference model.
    logic [15:0] m_stg [9];
    logic [15:0] m_act [9];
    bit          m_ven, m_pend, m_eov_q, m_irq;
    int          m_mode, m_tmo, m_ucnt;
    logic [15:0] m_rdata;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [15:0] fmask(input logic [3:0] a, input logic [15:0] d);
        if (a == 4'd0) return d & 16'h001F;
        if (a == 4'd1 || a == 4'd2 || a == 4'd5 || a == 4'd6) return d & 16'h00FF;
        return d;
    endfunction

    task automatic model_step();
        logic [15:0] rv;
        bit edge_now, pend_vis;
        if (!d_rst_n) begin
            for (int i = 0; i < 9; i++) begin
                m_stg[i] = '0;
                m_act[i] = '0;
            end
            m_ven = 0; m_pend = 0; m_eov_q = 0; m_irq = 0;
            m_mode = 0; m_tmo = 0; m_ucnt = 0; m_rdata = '0;
            return;
        end
        edge_now = d_eov && !m_eov_q;
        pend_vis = m_pend && (m_mode != 0);
        rv = '0;
        if (d_addr <= 4'd8) rv = m_stg[d_addr];
        else if (d_addr == 4'd9) rv = {13'd0, pend_vis, 2'(m_mode)};
`ifdef VID_UNDERRUN_CNT_EN
        else if (d_addr == 4'd10) rv = 16'(m_ucnt);
`endif
        if (d_rd) m_rdata = rv;
        m_irq = edge_now && (m_mode == 1);
        if (m_mode != 0 && d_lr && !d_lv && m_ucnt < UCNT_MAX) m_ucnt++;
        if (d_wr && d_addr == 4'd10) m_ucnt = 0;
        case (m_mode)
            0: begin
                if (d_commit || m_pend) begin
                    for (int i = 0; i < 9; i++) m_act[i] = m_stg[i];
                    m_ven  = m_stg[0][0];
                    m_mode = m_ven ? 1 : 0;
                end
                m_pend = 0;
            end
            1: begin
                if (edge_now && m_pend) begin
                    for (int i = 0; i < 9; i++) m_act[i] = m_stg[i];
                    m_pend = 0;
                    if (!m_stg[0][0]) begin
                        m_mode = 2;
                        m_tmo  = 0;
                    end
                end else if (d_commit) m_pend = 1;
            end
            default: begin
                if (d_commit) m_pend = 1;
                if (edge_now || m_tmo == int'(STOP_TMO) - 1) begin
                    m_ven  = 0;
                    m_mode = 0;
                end else m_tmo++;
            end
        endcase
        if (d_wr && d_addr <= 4'd8) m_stg[d_addr] = fmask(d_addr, d_wdata);
        m_eov_q = d_eov;
    endtask

    task automatic check_all();
        check("ven", ctrl_ven, m_ven);
        check("hsync_pol", ctrl_hsync_pol, m_act[0][1]);
        check("vsync_pol", ctrl_vsync_pol, m_act[0][2]);
        check("blank_pol", ctrl_blank_pol, m_act[0][3]);
        check("daten_pol", ctrl_daten_pol, m_act[0][4]);
        check("Thsync", Thsync, m_act[1][7:0]);
        check("Thgdel", Thgdel, m_act[2][7:0]);
        check("Thgate", Thgate, m_act[3]);
        check("Thlen", Thlen, m_act[4]);
        check("Tvsync", Tvsync, m_act[5][7:0]);
        check("Tvgdel", Tvgdel, m_act[6][7:0]);
        check("Tvgate", Tvgate, m_act[7]);
        check("Tvlen", Tvlen, m_act[8]);
        check("commit_pend", commit_pend, m_pend && (m_mode != 0));
        check("frame_irq", frame_irq, m_irq);
        check("rdata", cfg.cfg_rdata, m_rdata);
    endtask

    // One clock: apply held stimulus at negedge, advance model, check at next negedge.
    task automatic tick();
        cfg.cfg_wr = d_wr; cfg.cfg_rd = d_rd; cfg.cfg_addr = d_addr;
        cfg.cfg_wdata = d_wdata; cfg.cfg_commit = d_commit;
        rst_n = d_rst_n; eov = d_eov; load_ready = d_lr; load_valid = d_lv;
        model_step();
        @(negedge clk);
        check_all();
        d_wr = 0; d_rd = 0; d_commit = 0;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
        d_wr = 1; d_addr = a; d_wdata = d;
        tick();
    endtask

    task automatic rd_reg(input logic [3:0] a);
        d_rd = 1; d_addr = a;
        tick();
    endtask

    task automatic commit();
        d_commit = 1;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int irq_cnt;
        d_wr = 0; d_rd = 0; d_commit = 0; d_eov = 0; d_lr = 0; d_lv = 0;
        d_rst_n = 0; d_addr = '0; d_wdata = '0;
        cfg.cfg_wr = 0; cfg.cfg_rd = 0; cfg.cfg_addr = '0; cfg.cfg_wdata = '0;
        cfg.cfg_commit = 0; rst_n = 0; eov = 0; load_ready = 0; load_valid = 0;
        @(negedge clk);
        idle(2);
        check("reset_ven", ctrl_ven, 0);
        d_rst_n = 1;
        idle(1);

        // Commit in IDLE starts video.
        wr_reg(4'd4, 16'd800);
        wr_reg(4'd8, 16'd525);
        wr_reg(4'd0, 16'h0001);
        commit();
        check("idle_thlen", Thlen, 800);
        check("idle_tvlen", Tvlen, 525);
        check("idle_ven", ctrl_ven, 1);
        rd_reg(4'd9);
        check("status_run", cfg.cfg_rdata, 16'h1);

        // Commit in RUN waits for the boundary; 3-clk eov is one boundary.
        wr_reg(4'd1, 16'd96);
        commit();
        idle(3);
        check("thsync_hold", Thsync, 0);
        check("pend_set", commit_pend, 1);
        irq_cnt = 0;
        d_eov = 1;
        tick();
        check("thsync_apply", Thsync, 96);
        irq_cnt += int'(frame_irq);
        tick(); irq_cnt += int'(frame_irq);
        tick(); irq_cnt += int'(frame_irq);
        d_eov = 0;
        tick(); irq_cnt += int'(frame_irq);
        tick(); irq_cnt += int'(frame_irq);
        check("irq_once", irq_cnt, 1);

        // Stop at the next boundary.
        wr_reg(4'd0, 16'h0000);
        commit();
        d_eov = 1;
        tick();
        check("stop_pend_ven", ctrl_ven, 1);
        rd_reg(4'd9);
        check("status_stop", cfg.cfg_rdata, 16'h2);
        d_eov = 0;
        tick();
        d_eov = 1;
        tick();
        check("stopped_ven", ctrl_ven, 0);
        d_eov = 0;
        idle(2);

        // Stop by timeout.
        wr_reg(4'd0, 16'h0001);
        commit();
        wr_reg(4'd0, 16'h0000);
        commit();
        d_eov = 1;
        tick();
        d_eov = 0;
        idle(15);
        check("tmo_before", ctrl_ven, 1);
        idle(1);
        check("tmo_fire", ctrl_ven, 0);

        // Write during the applying edge; commit together with eov waits a frame.
        wr_reg(4'd0, 16'h0001);
        commit();
        commit();
        d_eov = 1; d_wr = 1; d_addr = 4'd2; d_wdata = 16'd40;
        tick();
        check("thgdel_old", Thgdel, 0);
        d_eov = 0;
        tick();
        rd_reg(4'd2);
        check("thgdel_staged", cfg.cfg_rdata, 40);
        d_commit = 1; d_eov = 1;
        tick();
        idle(2);
        d_eov = 0;
        idle(5);
        check("commit_waits", commit_pend, 1);
        check("thgdel_wait", Thgdel, 0);
        d_eov = 1;
        tick();
        check("thgdel_apply", Thgdel, 40);
        d_eov = 0;
        tick();

        // Underrun counting and clear.
        d_lr = 1; d_lv = 0;
        idle(20);
        d_lr = 0;
        rd_reg(4'hA);
`ifdef VID_UNDERRUN_CNT_EN
        check("ucnt_sat", cfg.cfg_rdata, 15);
`else
        check("ucnt_off", cfg.cfg_rdata, 0);
`endif
        wr_reg(4'hA, 16'h1234);
        rd_reg(4'hA);
        check("ucnt_clear", cfg.cfg_rdata, 0);

        // Reset while stopping with a pending commit.
        wr_reg(4'd0, 16'h0000);
        commit();
        d_eov = 1;
        tick();
        d_eov = 0;
        commit();
        check("sp_pend", commit_pend, 1);
        d_rst_n = 0;
        tick();
        d_rst_n = 1;
        check("rst_ven", ctrl_ven, 0);
        check("rst_thlen", Thlen, 0);
        check("rst_pend", commit_pend, 0);
        rd_reg(4'd9);
        check("rst_status", cfg.cfg_rdata, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            d_rst_n  = ($urandom_range(0, 499) != 0);
            d_wr     = ($urandom_range(0, 3) == 0);
            d_rd     = ($urandom_range(0, 2) == 0);
            d_commit = ($urandom_range(0, 15) == 0);
            d_addr   = 4'($urandom_range(0, 11));
            d_wdata  = 16'($urandom);
            if (d_wr && d_addr == 4'd0 && $urandom_range(0, 1) == 0) d_wdata[0] = 1'b1;
            if (d_eov) d_eov = ($urandom_range(0, 2) != 0);
            else d_eov = ($urandom_range(0, 24) == 0);
            d_lr = ($urandom_range(0, 1) == 0);
            d_lv = ($urandom_range(0, 1) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/video_timing_sched.md
Name: video_timing_sched

Overview:
- Configuration and sequencing controller for the video pixel generator.
- Holds a staging copy of every timing and polarity field, written through a simple register port.
- Applies staged values to the generator atomically: immediately when stopped, otherwise only at an end-of-frame boundary.
- Sequences video enable and disable at frame boundaries. Counts pixel-data underruns.

Parameters:
- STOP_TMO, 20'hFFFFF, clk cycles to wait for end of frame in STOP_PEND before forcing the stop.
- UCNT_W, 16, width of the saturating underrun counter (range 1..16).

Ports:
- clk  in  1  system clock, the same clock that drives the pixel generator.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_wr  in  1  register write strobe, one word per cycle.
- cfg_rd  in  1  register read strobe.
- cfg_addr  in  4  register address.
- cfg_wdata  in  16  write data.
- cfg_rdata  out  16  read data, registered.
- cfg_commit  in  1  request to apply the staging registers.
- eov  in  1  end-of-vertical from the pixel generator; level, may last several clk.
- load_ready  in  1  pixel generator requesting data (active gate).
- load_valid  in  1  pixel source data valid.
- ctrl_ven  out  1  video enable.
- ctrl_hsync_pol, ctrl_vsync_pol, ctrl_blank_pol, ctrl_daten_pol  out  1 each  active polarity bits.
- Thsync, Thgdel, Tvsync, Tvgdel  out  8 each  active timing.
- Thgate, Thlen, Tvgate, Tvlen  out  16 each  active timing.
- commit_pend  out  1  a commit is waiting for a frame boundary.
- frame_irq  out  1  one-clk pulse per frame boundary while running.

Behaviour:
- Register map (write goes to staging; read returns staging unless noted). Writes to 8-bit fields keep wdata[7:0]. Unmapped addresses: write ignored, read 0.
  - 0: CTRL {pol_d[4], pol_b[3], pol_v[2], pol_h[1], ven[0]}
  - 1: Thsync; 2: Thgdel; 3: Thgate; 4: Thlen
  - 5: Tvsync; 6: Tvgdel; 7: Tvgate; 8: Tvlen
  - 9: STATUS (read-only) {commit_pend[2], state[1:0]}
  - A: underrun count. Reading returns the count; writing any value clears it.
- cfg_rdata updates 1 cycle after cfg_rd and holds its value otherwise.
- Frame boundary:
  - eov_edge = eov & ~eov_q, where eov_q is eov registered.
  - Only eov_edge counts as a boundary; a multi-cycle eov is one boundary.
- States: IDLE=0, RUN=1, STOP_PEND=2.
- IDLE:
  - ctrl_ven=0.
  - On cfg_commit, all active outputs are loaded from staging on the next edge.
  - If staged ven=1, go to RUN with ctrl_ven=1 in that same cycle.
  - If staged ven=0, stay in IDLE.
  - commit_pend never asserts in IDLE.
- RUN:
  - cfg_commit sets commit_pend.
  - On the first eov_edge with commit_pend=1:
    - If staged ven=1: load all actives, clear commit_pend, stay in RUN.
    - If staged ven=0: load all actives except ven, go to STOP_PEND, clear commit_pend.
  - frame_irq pulses on every eov_edge in RUN.
- STOP_PEND:
  - ctrl_ven stays 1 until the next eov_edge or timeout; then ctrl_ven=0 and go to IDLE.
  - The timeout counter resets on entry and fires when it reaches STOP_TMO-1.
  - cfg_commit in this state is latched into commit_pend and evaluated as an IDLE commit on the first cycle in IDLE.
- Simultaneous events:
  - cfg_wr and apply in the same cycle: apply uses the staging value from before the write.
  - cfg_commit and eov_edge in the same cycle: the commit waits for the next boundary.
  - A repeated commit while commit_pend=1 has no further effect.
  - Writes are allowed while pending; the staging contents at apply time are used.
- Underrun:
  - In RUN and STOP_PEND, each cycle with load_ready & ~load_valid increments the counter.
  - The counter saturates at 2^UCNT_W-1.
  - A clear write in the same cycle as an increment wins (result 0).
- Reset (rst_n=0 at clk edge), including mid-frame or mid-stop:
  - state=IDLE.
  - All staging and active fields = 0, so ctrl_ven=0.
  - commit_pend=0, frame_irq=0, cfg_rdata=0, underrun count=0, eov_q=0, timeout counter=0.

Optional Feature:
- Macro VID_UNDERRUN_CNT_EN.
- Defined: the underrun counter and address A behave as above.
- Undefined: no counter logic; address A reads 0 and writes are ignored.

Test Plan:
- Write Thlen=800, Tvlen=525 and CTRL=0x01, then commit in IDLE -> next cycle Thlen=800, Tvlen=525, ctrl_ven=1, STATUS reads 0x1.
- In RUN, write Thsync=96 and commit -> Thsync unchanged and commit_pend=1 until an eov rising edge; Thsync=96 the cycle after; frame_irq pulses once for a 3-clk eov.
- Stage CTRL=0x00 and commit in RUN -> at eov edge: STOP_PEND, ctrl_ven=1; at the next eov edge: ctrl_ven=0, IDLE. With STOP_TMO=16 and no eov: ctrl_ven=0 after 16 clk.
- Write Thgdel=40 in the same cycle as the applying eov edge -> old value applied, 40 stays in staging; a commit with eov asserted together waits one full frame.
- With VID_UNDERRUN_CNT_EN and UCNT_W=4: hold load_ready=1, load_valid=0 for 20 clk -> count reads 15; write A -> 0. Without the macro, the count reads 0.
- Assert rst_n=0 for 1 clk while in STOP_PEND with commit_pend=1 -> all outputs 0, state IDLE.
